// File: rtl/regfile_sb_if.sv
// Decode/write-back facing bus of the scoreboarded register file.
// The master side is the pipeline (read, allocate, write, flush); the
// slave side is the register file itself.
interface regfile_sb_if #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int NRD  = 2
);
  localparam int AW = $clog2(NREG);
  localparam int CW = $clog2(NREG + 1);

  logic [NRD*AW-1:0]   ra;
  logic [NRD*XLEN-1:0] rd;
  logic [NRD-1:0]      rbusy;
  logic                we;
  logic [AW-1:0]       wa;
  logic [XLEN-1:0]     wd;
  logic                alloc_valid;
  logic [AW-1:0]       alloc_addr;
  logic                alloc_ready;
  logic                flush;
  logic [CW-1:0]       busy_cnt;

  modport master (
    output ra, we, wa, wd, alloc_valid, alloc_addr, flush,
    input  rd, rbusy, alloc_ready, busy_cnt
  );

  modport slave (
    input  ra, we, wa, wd, alloc_valid, alloc_addr, flush,
    output rd, rbusy, alloc_ready, busy_cnt
  );
endinterface

// File: rtl/regfile_sb.sv
// Multi-read-port integer register file with a write-back scoreboard.
// Reads are combinational with optional same-cycle write forwarding;
// each register carries a busy bit set by decode allocation and cleared
// by the write-back write or by a flush.
module regfile_sb #(
  parameter int XLEN     = 64,
  parameter int NREG     = 32,
  parameter int NRD      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  regfile_sb_if.slave  bus
);
  localparam int AW = $clog2(NREG);
  localparam int CW = $clog2(NREG + 1);
  localparam bit BP = (BYPASS != 0);
  localparam bit ZR = (ZERO_REG != 0);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic [CW-1:0]   cnt;

  logic wa_zero;
  logic aa_zero;
  logic wr_ok;
  logic alloc_rdy;
  logic alloc_fire;

  function automatic logic [CW-1:0] popcnt(input logic [NREG-1:0] v);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < NREG; i++) n = n + CW'(v[i]);
    return n;
  endfunction

  assign wa_zero = ZR && (bus.wa == '0);
  assign aa_zero = ZR && (bus.alloc_addr == '0);
  assign wr_ok   = bus.we && !wa_zero;

  // A pending write to the requested register frees it in the same edge,
  // so the allocation can be taken; register 0 is never really allocated.
  assign alloc_rdy  = !busy[bus.alloc_addr] || (bus.we && bus.wa == bus.alloc_addr) || aa_zero;
  assign alloc_fire = bus.alloc_valid && alloc_rdy && !aa_zero;

  // Next busy vector: write clears, allocation overrides write, flush overrides all
  always_comb begin
    busy_nxt = busy;
    if (bus.we)     busy_nxt[bus.wa] = 1'b0;
    if (alloc_fire) busy_nxt[bus.alloc_addr] = 1'b1;
    if (bus.flush)  busy_nxt = '0;
  end

  // Register storage; writes to a hardwired zero register are dropped
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[bus.wa] <= wd_q();
    end
  end

  function automatic logic [XLEN-1:0] wd_q();
    return bus.wd;
  endfunction

  // Busy vector and its population count move together on the same edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy <= '0;
      cnt  <= '0;
    end else begin
      busy <= busy_nxt;
      cnt  <= popcnt(busy_nxt);
    end
  end

  assign bus.alloc_ready = alloc_rdy;
  assign bus.busy_cnt    = cnt;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;
    logic            b;
    logic            hit;

    assign a   = bus.ra[k*AW +: AW];
    assign hit = BP && bus.we && (bus.wa == a);

    // Read mux: zero register first, then forwarded write, then storage
    always_comb begin
      d = regs[a];
      if (hit && !wa_zero) d = bus.wd;
      if (ZR && a == '0)   d = '0;
    end

    // Forwarded write shows the register as free unless it is re-allocated now
    always_comb begin
      b = busy[a];
      if (hit && !(alloc_fire && bus.alloc_addr == a)) b = 1'b0;
    end

    assign bus.rd[k*XLEN +: XLEN] = d;
    assign bus.rbusy[k]           = b;
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Directed scoreboard bench for regfile_sb: a bypassing instance and a
// non-bypassing instance share stimulus; expected outputs are queued by
// the driver and compared by a monitor on the falling clock edge.
module tb_regfile_sb;
  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  // kind: 0 rd, 1 rbusy, 2 busy_cnt, 3 alloc_ready; +4 selects the BYPASS=0 copy
  typedef struct {
    int          kind;
    int          port;
    logic [63:0] val;
    string       name;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  logic clk;
  logic reset_n;

  regfile_sb_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) bus ();
  regfile_sb_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) bus0 ();

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(1), .ZERO_REG(1)) u_dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave)
  );

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(0), .ZERO_REG(1)) u_nb (
    .clk(clk), .reset_n(reset_n), .bus(bus0.slave)
  );

  assign bus0.ra          = bus.ra;
  assign bus0.we          = bus.we;
  assign bus0.wa          = bus.wa;
  assign bus0.wd          = bus.wd;
  assign bus0.alloc_valid = bus.alloc_valid;
  assign bus0.alloc_addr  = bus.alloc_addr;
  assign bus0.flush       = bus.flush;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // Monitor: drain every expectation queued for this cycle
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [63:0] act;
      e = q.pop_front();
      act = '0;
      case (e.kind)
        0: act = bus.rd[e.port*XLEN +: XLEN];
        1: act = 64'(bus.rbusy[e.port]);
        2: act = 64'(bus.busy_cnt);
        3: act = 64'(bus.alloc_ready);
        4: act = bus0.rd[e.port*XLEN +: XLEN];
        5: act = 64'(bus0.rbusy[e.port]);
        6: act = 64'(bus0.busy_cnt);
        default: act = 64'(bus0.alloc_ready);
      endcase
      total++;
      if (act !== e.val) begin
        bad++;
        $display("FAIL %s port%0d: got %h expected %h", e.name, e.port, act, e.val);
      end
    end
  end

  task automatic expect_(input int kind, input int port, input logic [63:0] val, input string name);
    exp_t e;
    e.kind = kind;
    e.port = port;
    e.val  = val;
    e.name = name;
    q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic setra(input int a0, input int a1);
    logic [AW-1:0] p0;
    logic [AW-1:0] p1;
    p0 = AW'(a0);
    p1 = AW'(a1);
    bus.ra = {p1, p0};
  endtask

  task automatic idle();
    bus.we          = 1'b0;
    bus.wa          = '0;
    bus.wd          = '0;
    bus.alloc_valid = 1'b0;
    bus.alloc_addr  = '0;
    bus.flush       = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    setra(0, 0);
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    expect_(0, 0, 64'd0, "rst_rd");
    expect_(0, 1, 64'd0, "rst_rd");
    expect_(1, 0, 64'd0, "rst_rbusy");
    expect_(2, 0, 64'd0, "rst_cnt");
    expect_(3, 0, 64'd1, "rst_ready");
    cyc();
    reset_n = 1'b1;

    // Sweep every address on both ports
    for (int i = 0; i < NREG; i++) begin
      setra(i, NREG - 1 - i);
      expect_(0, 0, 64'd0, "sweep_rd");
      expect_(0, 1, 64'd0, "sweep_rd");
      expect_(1, 0, 64'd0, "sweep_rbusy");
      expect_(1, 1, 64'd0, "sweep_rbusy");
      expect_(2, 0, 64'd0, "sweep_cnt");
      cyc();
    end

    // Write reg 1 all ones, then hold we=0 with wd=0
    bus.we = 1'b1; bus.wa = 5'd1; bus.wd = ONES; setra(1, 0);
    expect_(0, 0, ONES, "wr1_bypass");
    expect_(4, 0, 64'd0, "wr1_nb_old");
    cyc();
    bus.we = 1'b0; bus.wd = '0;
    expect_(0, 0, ONES, "wr1_hold");
    expect_(4, 0, ONES, "wr1_nb_hold");
    cyc();
    expect_(0, 0, ONES, "wr1_hold2");
    cyc();

    // Writes to register 0 are dropped
    bus.we = 1'b1; bus.wa = 5'd0; bus.wd = ONES; setra(0, 1);
    expect_(0, 0, 64'd0, "wr0_bypass");
    expect_(4, 0, 64'd0, "wr0_nb");
    expect_(0, 1, ONES, "wr0_other");
    cyc();
    bus.we = 1'b0;
    expect_(0, 0, 64'd0, "wr0_after");
    expect_(4, 0, 64'd0, "wr0_nb_after");
    cyc();

    // Same-cycle forwarding vs. next-cycle visibility
    bus.we = 1'b1; bus.wa = 5'd5; bus.wd = 64'h1234; setra(5, 1);
    expect_(0, 0, 64'h1234, "byp_same");
    expect_(4, 0, 64'd0, "nb_same_old");
    cyc();
    bus.we = 1'b0; bus.wd = '0;
    expect_(0, 0, 64'h1234, "byp_next");
    expect_(4, 0, 64'h1234, "nb_next");
    cyc();

    // Allocate reg 7, re-allocate refused, then write-back clears
    bus.alloc_valid = 1'b1; bus.alloc_addr = 5'd7; setra(7, 5);
    expect_(3, 0, 64'd1, "alloc7_ready");
    expect_(1, 0, 64'd0, "alloc7_rb_pre");
    expect_(2, 0, 64'd0, "alloc7_cnt_pre");
    cyc();
    expect_(3, 0, 64'd0, "alloc7_again");
    expect_(1, 0, 64'd1, "alloc7_rb");
    expect_(2, 0, 64'd1, "alloc7_cnt");
    cyc();
    bus.alloc_valid = 1'b0; bus.we = 1'b1; bus.wa = 5'd7; bus.wd = 64'd77;
    expect_(1, 0, 64'd0, "wb7_rb_byp");
    expect_(5, 0, 64'd1, "wb7_nb_rb");
    expect_(2, 0, 64'd1, "wb7_cnt");
    expect_(6, 0, 64'd1, "wb7_nb_cnt");
    expect_(3, 0, 64'd1, "wb7_ready");
    expect_(7, 0, 64'd1, "wb7_nb_ready");
    expect_(0, 0, 64'd77, "wb7_rd");
    cyc();
    bus.we = 1'b0;
    expect_(1, 0, 64'd0, "wb7_rb_after");
    expect_(5, 0, 64'd0, "wb7_nb_rb_after");
    expect_(2, 0, 64'd0, "wb7_cnt_after");
    expect_(0, 0, 64'd77, "wb7_rd_after");
    cyc();

    // Write and allocate reg 7 together: data written, busy ends at 1
    bus.we = 1'b1; bus.wa = 5'd7; bus.wd = 64'd88;
    bus.alloc_valid = 1'b1; bus.alloc_addr = 5'd7;
    expect_(3, 0, 64'd1, "wa7_ready");
    expect_(1, 0, 64'd0, "wa7_rb");
    expect_(0, 0, 64'd88, "wa7_rd");
    cyc();
    bus.we = 1'b0; bus.alloc_valid = 1'b0;
    expect_(0, 0, 64'd88, "wa7_rd_after");
    expect_(1, 0, 64'd1, "wa7_rb_after");
    expect_(2, 0, 64'd1, "wa7_cnt_after");
    cyc();
    bus.we = 1'b1; bus.wd = 64'd99; bus.alloc_valid = 1'b1;
    expect_(3, 0, 64'd1, "wa7b_ready");
    expect_(1, 0, 64'd1, "wa7b_rb");
    cyc();
    bus.we = 1'b0; bus.alloc_valid = 1'b0;
    expect_(0, 0, 64'd99, "wa7b_rd");
    expect_(1, 0, 64'd1, "wa7b_rb_after");
    expect_(2, 0, 64'd1, "wa7b_cnt");
    cyc();

    // Flush alone
    bus.flush = 1'b1;
    cyc();
    bus.flush = 1'b0;
    expect_(2, 0, 64'd0, "flush_cnt");
    expect_(1, 0, 64'd0, "flush_rb");
    cyc();

    // Allocate 1..31
    for (int i = 1; i < NREG; i++) begin
      bus.alloc_valid = 1'b1; bus.alloc_addr = AW'(i);
      expect_(3, 0, 64'd1, "fill_ready");
      cyc();
    end
    bus.alloc_valid = 1'b0; bus.alloc_addr = 5'd2; setra(31, 2);
    expect_(2, 0, 64'd31, "fill_cnt");
    expect_(1, 0, 64'd1, "fill_rb");
    expect_(1, 1, 64'd1, "fill_rb");
    expect_(3, 0, 64'd0, "fill_ready_busy");
    cyc();
    bus.alloc_valid = 1'b1; bus.alloc_addr = 5'd0; setra(0, 2);
    expect_(3, 0, 64'd1, "alloc0_ready");
    cyc();
    bus.alloc_valid = 1'b0;
    expect_(1, 0, 64'd0, "alloc0_rb");
    expect_(2, 0, 64'd31, "alloc0_cnt");
    cyc();

    // Flush beats a same-cycle accepted allocation; the write still lands
    bus.flush = 1'b1; bus.we = 1'b1; bus.wa = 5'd2; bus.wd = 64'd5;
    bus.alloc_valid = 1'b1; bus.alloc_addr = 5'd2; setra(31, 2);
    expect_(3, 0, 64'd1, "fl_ready");
    expect_(2, 0, 64'd31, "fl_cnt_pre");
    expect_(0, 1, 64'd5, "fl_rd_byp");
    expect_(1, 1, 64'd1, "fl_rb_realloc");
    cyc();
    idle();
    expect_(2, 0, 64'd0, "fl_cnt");
    expect_(0, 1, 64'd5, "fl_rd");
    cyc();
    for (int i = 0; i < NREG; i++) begin
      setra(i, i);
      expect_(1, 0, 64'd0, "fl_sweep_rb");
      cyc();
    end

    // Asynchronous reset between edges
    bus.we = 1'b1; bus.wa = 5'd9; bus.wd = 64'hABC;
    bus.alloc_valid = 1'b1; bus.alloc_addr = 5'd9;
    cyc();
    idle();
    bus.alloc_addr = 5'd9; setra(9, 1);
    expect_(0, 0, 64'hABC, "pre_rst_rd");
    expect_(0, 1, ONES, "pre_rst_rd1");
    expect_(1, 0, 64'd1, "pre_rst_rb");
    expect_(2, 0, 64'd1, "pre_rst_cnt");
    expect_(3, 0, 64'd0, "pre_rst_ready");
    cyc();
    #1;
    reset_n = 1'b0;
    #1;
    total++;
    if (bus.rd[0 +: XLEN] !== 64'd0) begin
      bad++;
      $display("FAIL arst_now_rd0: got %h", bus.rd[0 +: XLEN]);
    end
    total++;
    if (bus.rd[XLEN +: XLEN] !== 64'd0) begin
      bad++;
      $display("FAIL arst_now_rd1: got %h", bus.rd[XLEN +: XLEN]);
    end
    total++;
    if (bus.busy_cnt !== '0) begin
      bad++;
      $display("FAIL arst_now_cnt: got %0d", bus.busy_cnt);
    end
    total++;
    if (bus.alloc_ready !== 1'b1) begin
      bad++;
      $display("FAIL arst_now_ready: got %b", bus.alloc_ready);
    end
    total++;
    if (bus.rbusy !== '0) begin
      bad++;
      $display("FAIL arst_now_rbusy: got %b", bus.rbusy);
    end
    total++;
    if (bus0.rd[0 +: XLEN] !== 64'd0) begin
      bad++;
      $display("FAIL arst_now_nb_rd: got %h", bus0.rd[0 +: XLEN]);
    end
    expect_(0, 0, 64'd0, "arst_rd");
    expect_(0, 1, 64'd0, "arst_rd1");
    expect_(1, 0, 64'd0, "arst_rb");
    expect_(2, 0, 64'd0, "arst_cnt");
    expect_(3, 0, 64'd1, "arst_ready");
    expect_(4, 0, 64'd0, "arst_nb_rd");
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    cyc();
    expect_(0, 0, 64'd0, "post_rst_rd");
    expect_(2, 0, 64'd0, "post_rst_cnt");
    cyc();

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    if (bad == 0 && total >= 12) $display("PASS");
    else $display("FAIL: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-read-port integer register file with an integrated write-back scoreboard. It is the next-generation register file for the pipelined core. Width, depth and read-port count are parameters. It adds selectable write-to-read bypass, an optionally hardwired-zero register 0, and per-register busy tracking with an allocate/release handshake. It sits between decode (read and allocate) and write-back (write and release).

## Interface
- XLEN, 64, data width in bits
- NREG, 32, number of registers; power of two, at least 2
- NRD, 2, number of read ports, 1..4
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports
- ZERO_REG, 1, when 1 register 0 reads 0, ignores writes and is never busy
- AW, derived as $clog2(NREG), address width

Ports:
- clk  in  1  single clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- ra  in  NRD*AW  read addresses; port k uses bits [k*AW +: AW]
- rd  out  NRD*XLEN  read data, combinational from ra
- rbusy  out  NRD  busy bit of the register addressed by each read port
- we  in  1  write enable
- wa  in  AW  write address
- wd  in  XLEN  write data
- alloc_valid  in  1  request to mark register alloc_addr busy
- alloc_addr  in  AW  destination to allocate
- alloc_ready  out  1  allocation accepted this cycle
- flush  in  1  synchronous clear of all busy bits
- busy_cnt  out  $clog2(NREG+1)  number of busy registers

## Operation
- Storage: NREG x XLEN flops plus an NREG busy vector.
- Reset (reset_n=0, asynchronous):
  - All registers go to 0 and all busy bits go to 0.
  - Consequences: rd=0, rbusy=0, busy_cnt=0, alloc_ready=1.
- Write: when we=1, at the rising edge reg[wa] <= wd and busy[wa] <= 0.
- Register 0 with ZERO_REG=1:
  - Writes to register 0 are dropped.
  - Allocations of register 0 are accepted (alloc_ready=1) but never set its busy bit.
- Read: rd[k] = reg[ra[k]].
  - With ZERO_REG=1 and ra[k]=0, rd[k]=0.
  - With BYPASS=1, we=1, wa=ra[k] and the address is not register 0 under ZERO_REG, rd[k]=wd.
- rbusy[k] = busy[ra[k]] as currently stored.
  - With BYPASS=1, a same-cycle write to ra[k] forces rbusy[k]=0, unless a same-cycle accepted allocation targets the same address.
- Allocate handshake:
  - alloc_ready = !busy[alloc_addr] || (we && wa==alloc_addr) || (ZERO_REG && alloc_addr==0).
  - Transfer occurs when alloc_valid && alloc_ready; at that edge busy[alloc_addr] <= 1.
  - A refused allocation changes nothing; the requester holds alloc_valid and alloc_addr until accepted.
- Simultaneous write and accepted allocation to the same address:
  - The data is written and busy ends at 1 (allocation wins).
- Flush:
  - At the edge, all busy bits clear, taking priority over any same-cycle allocation.
  - A same-cycle write still updates data.
  - alloc_ready is unaffected by flush in the same cycle.
- busy_cnt: registered population count of the busy vector, updated on the same edge as the vector.

## Timing
- Read latency: 0 cycles (combinational).
- Write visible on rd:
  - BYPASS=1: in the same cycle.
  - BYPASS=0: from the cycle after the edge.
- Busy set: an allocation accepted at edge N shows rbusy=1 from cycle N+1.
- Busy clear: a write at edge N clears the busy bit from cycle N+1; with BYPASS=1 rbusy shows 0 during the write cycle.
- alloc_ready: combinational from alloc_addr, we, wa and the busy vector. There is no path from alloc_valid to alloc_ready.
- Reset mid-operation: immediate clear regardless of clk; no pending allocation survives.
- Every address in 0..NREG-1 is valid. No wrap-around is needed because NREG is a power of two.

## Test plan
- Reset, then sweep ra over 0..31 on every port -> all rd=0, rbusy=0, busy_cnt=0.
- Write reg 1 = 64'hFFFF_FFFF_FFFF_FFFF, then hold we=0 and present wd=0 to reg 1 -> rd=all ones on both edges. Write reg 0 = all ones -> rd for register 0 stays 0 (ZERO_REG=1).
- BYPASS=1: we=1, wa=5, wd=64'h1234, ra0=5 -> rd0=64'h1234 in the same cycle. Repeat with BYPASS=0 -> rd0=old value, then 64'h1234 after the edge.
- Allocate reg 7 -> rbusy=1 and busy_cnt=1. Allocate reg 7 again -> alloc_ready=0. Write reg 7 -> rbusy=0 next cycle and busy_cnt=0. Write and allocate reg 7 in the same cycle -> data updated and busy stays 1.
- Allocate regs 1..31 in 31 cycles -> busy_cnt=31. Assert flush together with an allocate of reg 2 -> busy_cnt=0 next cycle and all rbusy=0.
- Drop reset_n asynchronously between edges with registers busy and written -> immediate rd=0, busy_cnt=0, alloc_ready=1.
